// File: rtl/intr_ctrl_n.sv
// Purpose : N-source light8080 interrupt controller. Edge/level sources, optional rotating priority, RST vector on INTA.
// Latency : ext_intr to cpu_intr is SYNC_STAGES+1 clocks; an INTA+RD read gives cpu_inst 1 clock later.
// Backpr. : the CPU paces the handshake. cpu_inst holds the vector until cpu_inta drops; no new arbitration happens meanwhile.
//
// Ports:
//   clock, reset_n           rising-edge clock, async active-low reset
//   ext_intr                 raw interrupt requests, active high
//   intr_ena                 per-source enable
//   intr_mode                per-source mode: 1 = rising edge, 0 = level
//   cpu_inte/inta/rd         CPU interrupt enable, acknowledge and read strobe
//   cpu_intr                 OR of the pending register
//   cpu_inst                 registered RST opcode; 0 outside an ack, so it can be OR-ed onto the bus
//   intr_pend                pending register, for status reads
//   intr_busy                handshake in progress
//   last_id                  index of the most recently acknowledged source
module intr_ctrl_n #(
    parameter int N_INTR      = 8,
    parameter int VEC_BASE    = 0,
    parameter int VEC_STEP    = 1,
    parameter int SYNC_STAGES = 2,
    parameter int ROTATE      = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [N_INTR-1:0] ext_intr,
    input  logic [N_INTR-1:0] intr_ena,
    input  logic [N_INTR-1:0] intr_mode,
    input  logic              cpu_inte,
    input  logic              cpu_inta,
    input  logic              cpu_rd,
    output logic              cpu_intr,
    output logic [7:0]        cpu_inst,
    output logic [N_INTR-1:0] intr_pend,
    output logic              intr_busy,
    output logic [2:0]        last_id
);

    localparam int IW = (N_INTR > 1) ? $clog2(N_INTR) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        HOLD     = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [N_INTR-1:0] s_w;
    logic [N_INTR-1:0] prev_q, prev_d;
    logic [N_INTR-1:0] rise;
    logic [N_INTR-1:0] clr;
    logic [N_INTR-1:0] pend_q, pend_d;
    logic [2:0]        sel_q, sel_d;
    logic [2:0]        rot_ptr_q, rot_ptr_d;
    logic [2:0]        last_id_q, last_id_d;
    logic [7:0]        inst_q, inst_d;
    logic [2:0]        win;
    logic              found;
    int                arb_idx;
    logic [7:0]        vec;
    logic [7:0]        opcode;

    // Input synchroniser; zero stages means the requests are already synchronous to clock.
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s_w = ext_intr;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0][N_INTR-1:0] sync_q, sync_d;

            always_comb begin
                sync_d    = sync_q;
                sync_d[0] = ext_intr;
                for (int k = 1; k < SYNC_STAGES; k++) begin
                    sync_d[k] = sync_q[k-1];
                end
            end

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= sync_d;
                end
            end

            assign s_w = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    always_comb begin
        prev_d = s_w;
        rise   = s_w & ~prev_q;
    end

    // Edge bits clear on ack, but a rise in the ack cycle wins and keeps the bit set.
    // Level bits simply follow the synchronised input.
    always_comb begin
        pend_d = '0;
        for (int i = 0; i < N_INTR; i++) begin
            if (intr_mode[i]) begin
                pend_d[i] = intr_ena[i] & ((pend_q[i] & ~clr[i]) | rise[i]);
            end else begin
                pend_d[i] = intr_ena[i] & s_w[i];
            end
        end
    end

    // Priority search. Fixed mode starts at bit 0; rotating mode starts at the
    // source after the last one acknowledged and wraps around.
    always_comb begin
        found   = 1'b0;
        win     = 3'd0;
        arb_idx = 0;
        for (int k = 0; k < N_INTR; k++) begin
            if (ROTATE != 0) begin
                arb_idx = int'(rot_ptr_q) + k;
            end else begin
                arb_idx = k;
            end
            if (arb_idx >= N_INTR) begin
                arb_idx = arb_idx - N_INTR;
            end
            if (!found && pend_q[IW'(arb_idx)]) begin
                found = 1'b1;
                win   = 3'(arb_idx);
            end
        end
    end

    always_comb begin
        vec    = 8'(VEC_BASE) + 8'(sel_q) * 8'(VEC_STEP);
        opcode = 8'hC7 | (vec << 3);
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        rot_ptr_d = rot_ptr_q;
        last_id_d = last_id_q;
        inst_d    = inst_q;
        clr       = '0;
        case (state_q)
            IDLE: begin
                if (found && cpu_inte) begin
                    sel_d   = win;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                // The latched source is delivered even if its pending bit has since
                // dropped; aborting here would leave the CPU waiting on a bus read.
                if (cpu_inta && cpu_rd) begin
                    inst_d    = opcode;
                    last_id_d = sel_q;
                    clr       = N_INTR'(1) << sel_q;
                    rot_ptr_d = (sel_q == 3'(N_INTR - 1)) ? 3'd0 : sel_q + 3'd1;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (!cpu_inta) begin
                    inst_d  = 8'd0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            prev_q    <= '0;
            pend_q    <= '0;
            sel_q     <= 3'd0;
            rot_ptr_q <= 3'd0;
            last_id_q <= 3'd0;
            inst_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            pend_q    <= pend_d;
            sel_q     <= sel_d;
            rot_ptr_q <= rot_ptr_d;
            last_id_q <= last_id_d;
            inst_q    <= inst_d;
        end
    end

    assign cpu_intr  = |pend_q;
    assign cpu_inst  = inst_q;
    assign intr_pend = pend_q;
    assign intr_busy = (state_q != IDLE);
    assign last_id   = last_id_q;

endmodule

// File: tb/tb_intr_ctrl_n.sv
module tb_intr_ctrl_n;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       cpu_inte, cpu_inta, cpu_rd;

    // legacy-map instance: N=4, BASE=1, STEP=2
    logic [3:0] ext_l, ena_l, mode_l, pend_l;
    logic       intr_l, busy_l;
    logic [7:0] inst_l;
    logic [2:0] lid_l;

    // default instance: N=8, fixed priority
    logic [7:0] ext_f, ena_f, mode_f, pend_f;
    logic       intr_f, busy_f;
    logic [7:0] inst_f;
    logic [2:0] lid_f;

    // rotating instance: N=8, ROTATE=1
    logic [7:0] ext_r, ena_r, mode_r, pend_r;
    logic       intr_r, busy_r;
    logic [7:0] inst_r;
    logic [2:0] lid_r;

    int checks = 0;
    int errors = 0;

    intr_ctrl_n #(.N_INTR(4), .VEC_BASE(1), .VEC_STEP(2), .SYNC_STAGES(2), .ROTATE(0)) u_leg (
        .clock(clock), .reset_n(reset_n), .ext_intr(ext_l), .intr_ena(ena_l), .intr_mode(mode_l),
        .cpu_inte(cpu_inte), .cpu_inta(cpu_inta), .cpu_rd(cpu_rd), .cpu_intr(intr_l),
        .cpu_inst(inst_l), .intr_pend(pend_l), .intr_busy(busy_l), .last_id(lid_l));

    intr_ctrl_n #(.N_INTR(8), .VEC_BASE(0), .VEC_STEP(1), .SYNC_STAGES(2), .ROTATE(0)) u_fix (
        .clock(clock), .reset_n(reset_n), .ext_intr(ext_f), .intr_ena(ena_f), .intr_mode(mode_f),
        .cpu_inte(cpu_inte), .cpu_inta(cpu_inta), .cpu_rd(cpu_rd), .cpu_intr(intr_f),
        .cpu_inst(inst_f), .intr_pend(pend_f), .intr_busy(busy_f), .last_id(lid_f));

    intr_ctrl_n #(.N_INTR(8), .VEC_BASE(0), .VEC_STEP(1), .SYNC_STAGES(2), .ROTATE(1)) u_rot (
        .clock(clock), .reset_n(reset_n), .ext_intr(ext_r), .intr_ena(ena_r), .intr_mode(mode_r),
        .cpu_inte(cpu_inte), .cpu_inta(cpu_inta), .cpu_rd(cpu_rd), .cpu_intr(intr_r),
        .cpu_inst(inst_r), .intr_pend(pend_r), .intr_busy(busy_r), .last_id(lid_r));

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // advance n rising edges, then settle 1 time unit past the edge
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset_n  = 1'b0;
        cpu_inte = 1'b0; cpu_inta = 1'b0; cpu_rd = 1'b0;
        ext_l = '0; ena_l = 4'hF; mode_l = 4'hF;
        ext_f = '0; ena_f = 8'hFF; mode_f = 8'hFF;
        ext_r = '0; ena_r = 8'hFF; mode_r = 8'h00;
        tick(3);
        checks++; if (inst_f !== 8'h00) begin errors++; $display("FAIL rst_inst got %h exp 00", inst_f); end
        checks++; if (pend_f !== 8'h00) begin errors++; $display("FAIL rst_pend got %h exp 00", pend_f); end
        checks++; if (intr_f !== 1'b0) begin errors++; $display("FAIL rst_intr got %b exp 0", intr_f); end
        checks++; if (busy_f !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy_f); end
        checks++; if (lid_f !== 3'd0) begin errors++; $display("FAIL rst_lid got %0d exp 0", lid_f); end
        checks++; if (inst_l !== 8'h00) begin errors++; $display("FAIL rst_inst_leg got %h exp 00", inst_l); end
        reset_n = 1'b1;
        tick(1);
        // inta+rd in IDLE must be ignored
        cpu_inta = 1'b1; cpu_rd = 1'b1;
        tick(1);
        checks++; if (inst_f !== 8'h00) begin errors++; $display("FAIL idle_inta_inst got %h exp 00", inst_f); end
        checks++; if (busy_f !== 1'b0) begin errors++; $display("FAIL idle_inta_busy got %b exp 0", busy_f); end
        cpu_inta = 1'b0; cpu_rd = 1'b0;
        tick(1);
    endtask

    task automatic test_legacy;
        cpu_inte = 1'b1;
        ext_l = 4'b0100;
        tick(1);
        ext_l = 4'b0000;
        tick(1);
        checks++; if (intr_l !== 1'b0) begin errors++; $display("FAIL leg_intr_2clk got %b exp 0", intr_l); end
        tick(1);
        checks++; if (intr_l !== 1'b1) begin errors++; $display("FAIL leg_intr_3clk got %b exp 1", intr_l); end
        checks++; if (pend_l !== 4'b0100) begin errors++; $display("FAIL leg_pend got %h exp 4", pend_l); end
        tick(1);
        checks++; if (busy_l !== 1'b1) begin errors++; $display("FAIL leg_busy got %b exp 1", busy_l); end
        cpu_inta = 1'b1; cpu_rd = 1'b1;
        tick(1);
        checks++; if (inst_l !== 8'hEF) begin errors++; $display("FAIL leg_inst got %h exp EF", inst_l); end
        checks++; if (pend_l !== 4'b0000) begin errors++; $display("FAIL leg_pend_clr got %h exp 0", pend_l); end
        checks++; if (lid_l !== 3'd2) begin errors++; $display("FAIL leg_lid got %0d exp 2", lid_l); end
        cpu_rd = 1'b0;
        tick(1);
        checks++; if (inst_l !== 8'hEF) begin errors++; $display("FAIL leg_inst_hold got %h exp EF", inst_l); end
        cpu_inta = 1'b0;
        tick(1);
        checks++; if (inst_l !== 8'h00) begin errors++; $display("FAIL leg_inst_drop got %h exp 00", inst_l); end
        checks++; if (busy_l !== 1'b0) begin errors++; $display("FAIL leg_busy_end got %b exp 0", busy_l); end
    endtask

    task automatic test_fixed_priority;
        ext_f = 8'h22;
        tick(1);
        ext_f = 8'h00;
        tick(2);
        checks++; if (pend_f !== 8'h22) begin errors++; $display("FAIL fix_pend got %h exp 22", pend_f); end
        tick(1);
        checks++; if (busy_f !== 1'b1) begin errors++; $display("FAIL fix_busy got %b exp 1", busy_f); end
        // inta without rd is ignored
        cpu_inta = 1'b1; cpu_rd = 1'b0;
        tick(1);
        checks++; if (inst_f !== 8'h00) begin errors++; $display("FAIL fix_inta_nord got %h exp 00", inst_f); end
        cpu_rd = 1'b1;
        tick(1);
        checks++; if (inst_f !== 8'hCF) begin errors++; $display("FAIL fix_inst1 got %h exp CF", inst_f); end
        checks++; if (lid_f !== 3'd1) begin errors++; $display("FAIL fix_lid1 got %0d exp 1", lid_f); end
        checks++; if (pend_f !== 8'h20) begin errors++; $display("FAIL fix_pend1 got %h exp 20", pend_f); end
        cpu_inta = 1'b0; cpu_rd = 1'b0;
        tick(1);
        checks++; if (inst_f !== 8'h00) begin errors++; $display("FAIL fix_inst_gap got %h exp 00", inst_f); end
        tick(1);
        cpu_inta = 1'b1; cpu_rd = 1'b1;
        tick(1);
        checks++; if (inst_f !== 8'hEF) begin errors++; $display("FAIL fix_inst2 got %h exp EF", inst_f); end
        checks++; if (lid_f !== 3'd5) begin errors++; $display("FAIL fix_lid2 got %0d exp 5", lid_f); end
        checks++; if (pend_f !== 8'h00) begin errors++; $display("FAIL fix_pend2 got %h exp 00", pend_f); end
        cpu_inta = 1'b0; cpu_rd = 1'b0;
        tick(1);
        checks++; if (busy_f !== 1'b0) begin errors++; $display("FAIL fix_busy_end got %b exp 0", busy_f); end
    endtask

    task automatic test_rotate;
        int         exp_id [4];
        logic [7:0] exp_op [4];
        exp_id = '{0, 3, 0, 3};
        exp_op = '{8'hC7, 8'hDF, 8'hC7, 8'hDF};
        ext_r = 8'h09;
        tick(3);
        checks++; if (pend_r !== 8'h09) begin errors++; $display("FAIL rot_pend got %h exp 09", pend_r); end
        for (int it = 0; it < 4; it++) begin
            tick(1);
            cpu_inta = 1'b1; cpu_rd = 1'b1;
            tick(1);
            checks++; if (lid_r !== 3'(exp_id[it])) begin errors++; $display("FAIL rot_lid%0d got %0d exp %0d", it, lid_r, exp_id[it]); end
            checks++; if (inst_r !== exp_op[it]) begin errors++; $display("FAIL rot_inst%0d got %h exp %h", it, inst_r, exp_op[it]); end
            checks++; if (pend_r !== 8'h09) begin errors++; $display("FAIL rot_level%0d got %h exp 09", it, pend_r); end
            cpu_inta = 1'b0; cpu_rd = 1'b0;
            tick(1);
        end
        // Source drops after a new arbitration already latched source 0;
        // the vector is still delivered.
        ext_r = 8'h00;
        tick(3);
        checks++; if (pend_r !== 8'h00) begin errors++; $display("FAIL rot_pend_drop got %h exp 00", pend_r); end
        checks++; if (busy_r !== 1'b1) begin errors++; $display("FAIL rot_busy_latched got %b exp 1", busy_r); end
        cpu_inta = 1'b1; cpu_rd = 1'b1;
        tick(1);
        checks++; if (inst_r !== 8'hC7) begin errors++; $display("FAIL rot_nophantom got %h exp C7", inst_r); end
        cpu_inta = 1'b0; cpu_rd = 1'b0;
        tick(1);
        checks++; if (busy_r !== 1'b0) begin errors++; $display("FAIL rot_busy_end got %b exp 0", busy_r); end
    endtask

    task automatic test_collision;
        ext_f = 8'h10;
        tick(1);
        ext_f = 8'h00;
        tick(2);
        checks++; if (pend_f !== 8'h10) begin errors++; $display("FAIL col_pend got %h exp 10", pend_f); end
        // second rise timed to reach the edge detector in the ack cycle
        ext_f = 8'h10;
        tick(1);
        ext_f = 8'h00;
        checks++; if (busy_f !== 1'b1) begin errors++; $display("FAIL col_busy got %b exp 1", busy_f); end
        tick(1);
        cpu_inta = 1'b1; cpu_rd = 1'b1;
        tick(1);
        checks++; if (inst_f !== 8'hE7) begin errors++; $display("FAIL col_inst1 got %h exp E7", inst_f); end
        checks++; if (pend_f !== 8'h10) begin errors++; $display("FAIL col_rise_wins got %h exp 10", pend_f); end
        cpu_inta = 1'b0; cpu_rd = 1'b0;
        tick(2);
        cpu_inta = 1'b1; cpu_rd = 1'b1;
        tick(1);
        checks++; if (inst_f !== 8'hE7) begin errors++; $display("FAIL col_inst2 got %h exp E7", inst_f); end
        checks++; if (pend_f !== 8'h00) begin errors++; $display("FAIL col_pend_clr got %h exp 00", pend_f); end
        cpu_inta = 1'b0; cpu_rd = 1'b0;
        tick(1);
    endtask

    task automatic test_masking;
        cpu_inte = 1'b0;
        ext_f = 8'h04;
        tick(1);
        ext_f = 8'h00;
        tick(2);
        checks++; if (pend_f !== 8'h04) begin errors++; $display("FAIL mask_pend got %h exp 04", pend_f); end
        checks++; if (intr_f !== 1'b1) begin errors++; $display("FAIL mask_intr_inte0 got %b exp 1", intr_f); end
        tick(2);
        checks++; if (busy_f !== 1'b0) begin errors++; $display("FAIL mask_idle_inte0 got %b exp 0", busy_f); end
        ena_f = 8'hFB;
        tick(1);
        checks++; if (pend_f !== 8'h00) begin errors++; $display("FAIL mask_ena_clr got %h exp 00", pend_f); end
        checks++; if (intr_f !== 1'b0) begin errors++; $display("FAIL mask_intr_off got %b exp 0", intr_f); end
        ena_f = 8'hFF;
        cpu_inte = 1'b1;
        tick(2);
        checks++; if (busy_f !== 1'b0) begin errors++; $display("FAIL mask_no_rearm got %b exp 0", busy_f); end
    endtask

    task automatic test_reset_mid;
        ext_l = 4'b1000;
        tick(1);
        ext_l = 4'b0000;
        tick(3);
        cpu_inta = 1'b1; cpu_rd = 1'b1;
        tick(1);
        checks++; if (inst_l !== 8'hFF) begin errors++; $display("FAIL rm_inst got %h exp FF", inst_l); end
        cpu_rd = 1'b0;
        ext_l = 4'b1000;
        tick(1);
        ext_l = 4'b0000;
        tick(2);
        checks++; if (pend_l !== 4'b1000) begin errors++; $display("FAIL rm_pend got %h exp 8", pend_l); end
        checks++; if (busy_l !== 1'b1) begin errors++; $display("FAIL rm_hold got %b exp 1", busy_l); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (inst_l !== 8'h00) begin errors++; $display("FAIL rm_async_inst got %h exp 00", inst_l); end
        checks++; if (busy_l !== 1'b0) begin errors++; $display("FAIL rm_async_busy got %b exp 0", busy_l); end
        checks++; if (pend_l !== 4'b0000) begin errors++; $display("FAIL rm_async_pend got %h exp 0", pend_l); end
        checks++; if (intr_l !== 1'b0) begin errors++; $display("FAIL rm_async_intr got %b exp 0", intr_l); end
        cpu_inta = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(1);
    endtask

    initial begin
        test_reset;
        test_legacy;
        test_fixed_priority;
        test_rotate;
        test_collision;
        test_masking;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
